// File: rtl/mul_vote_pkg.sv
// rtl/mul_vote_pkg.sv - shared types and saturating arithmetic for the voted multiplier stages
package mul_vote_pkg;

    localparam int PROD_W = 16;
    localparam int SAT_MAX_W = 32;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    typedef struct packed {
        logic        clamped;
        logic [31:0] value;
    } sat_res_t;

    // Adds inc to base and clamps to the all-ones value of a width-bit register (width <= 32).
    function automatic sat_res_t sat_inc(input logic [31:0] base, input logic [31:0] inc,
                                         input int width);
        sat_res_t    r;
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, base} + {1'b0, inc};
        lim = (33'd1 << width) - 33'd1;
        if (sum > lim) begin
            r.clamped = 1'b1;
            r.value   = lim[31:0];
        end else begin
            r.clamped = 1'b0;
            r.value   = sum[31:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/tmr_vote16.sv
// rtl/tmr_vote16.sv - bitwise 2-of-3 majority voter with copy-disagreement flags
import mul_vote_pkg::*;

module tmr_vote16 (
    input  logic [PROD_W-1:0] prod_a,
    input  logic [PROD_W-1:0] prod_b,
    input  logic [PROD_W-1:0] prod_c,
    output logic [PROD_W-1:0] v,
    output logic              mism,
    output logic              multi
);

    logic mis_a;
    logic mis_b;
    logic mis_c;

    assign v     = (prod_a & prod_b) | (prod_a & prod_c) | (prod_b & prod_c);
    assign mis_a = (prod_a != v);
    assign mis_b = (prod_b != v);
    assign mis_c = (prod_c != v);
    assign mism  = mis_a | mis_b | mis_c;
    // At least two of the three flags set.
    assign multi = (mis_a & mis_b) | (mis_a & mis_c) | (mis_b & mis_c);

endmodule

// File: rtl/mul_vote_acc.sv
// rtl/mul_vote_acc.sv - votes triplicated products and accumulates them per packet
import mul_vote_pkg::*;

module mul_vote_acc #(
    parameter int ACC_W = 24,
    parameter int ERR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [PROD_W-1:0] prod_a,
    input  logic [PROD_W-1:0] prod_b,
    input  logic [PROD_W-1:0] prod_c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              multi_fault,
    output logic              sat
);

    state_t            state;
    logic [ACC_W-1:0]  acc;
    logic [ERR_W-1:0]  err;
    logic              multi_r;
    logic              sat_r;

    logic [PROD_W-1:0] v;
    logic              mism;
    logic              multi;
    logic              acc_fire;
    sat_res_t          acc_nxt;
    sat_res_t          err_nxt;

    tmr_vote16 u_vote (
        .prod_a (prod_a),
        .prod_b (prod_b),
        .prod_c (prod_c),
        .v      (v),
        .mism   (mism),
        .multi  (multi)
    );

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign acc_fire  = in_valid & in_ready;

    always_comb begin
        acc_nxt = sat_inc(32'(acc), 32'(v), ACC_W);
        err_nxt = sat_inc(32'(err), 32'd1, ERR_W);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ACCUM;
            acc     <= '0;
            err     <= '0;
            multi_r <= 1'b0;
            sat_r   <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (acc_fire) begin
                        acc <= acc_nxt.value[ACC_W-1:0];
                        if (acc_nxt.clamped)
                            sat_r <= 1'b1;
                        if (mism)
                            err <= err_nxt.value[ERR_W-1:0];
                        if (multi)
                            multi_r <= 1'b1;
                        if (in_last)
                            state <= DONE;
                    end
                end
                DONE: begin
                    // Result is frozen here; the handshake also starts the next packet from zero.
                    if (out_ready) begin
                        state   <= ACCUM;
                        acc     <= '0;
                        err     <= '0;
                        multi_r <= 1'b0;
                        sat_r   <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign acc_out     = acc;
    assign err_cnt     = err;
    assign multi_fault = multi_r;
    assign sat         = sat_r;

endmodule

// File: doc/mul_vote_acc.md
# mul_vote_acc

Sequential consumer placed directly downstream of the triplicated 8x8 approximate Wallace multiplier. It accepts the three redundant 16-bit product copies each beat and majority-votes them bit by bit. It counts beats where the copies disagree, and accumulates the voted products over a packet delimited by `in_last`. At packet end it presents the saturated sum and fault statistics on a valid/ready output port.

## Interface
- `ACC_W`, default 24: accumulator and sum width; must be ≥16.
- `ERR_W`, default 8: width of the per-packet disagreement counter.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `in_valid`  in  1: beat available on `prod_a/b/c`.
- `in_ready`  out  1: block can accept a beat.
- `in_last`  in  1: accepted beat is the final beat of the packet.
- `prod_a`, `prod_b`, `prod_c`  in  16 each: redundant multiplier product copies.
- `out_valid`  out  1: packet result held stable.
- `out_ready`  in  1: downstream accepts result.
- `acc_out`  out  ACC_W: saturated sum of voted products.
- `err_cnt`  out  ERR_W: beats in packet with any copy mismatch; saturating.
- `multi_fault`  out  1: some beat had ≥2 copies differing from the voted word.
- `sat`  out  1: accumulator saturated during packet.

## Operation
- Accept: `acc_fire = in_valid & in_ready`; `in_ready = ~out_valid`.
- Vote: `v = (a&b)|(a&c)|(b&c)`, computed bitwise and combinationally.
- Per beat:
  - `mis_k = (prod_k != v)`.
  - `mism = mis_a|mis_b|mis_c`.
  - `multi = (mis_a+mis_b+mis_c) >= 2`.
- Accumulate on `acc_fire`: `acc <= min(acc + zero-extended v, 2^ACC_W-1)`. `sat` sets sticky when the clamp engages, including an exact overflow carry.
- `err_cnt` increments on `acc_fire & mism` and holds at all-ones. `multi_fault` is sticky-set on `acc_fire & multi`.
- FSM states:
  - ACCUM (reset state): accepts beats. `acc_fire & in_last` → DONE, with the final beat's contribution included.
  - DONE: `out_valid=1`, outputs frozen, `in_ready=0`. `out_valid & out_ready` → ACCUM, clearing `acc`, `err_cnt`, `multi_fault` and `sat` to 0 on that edge.
- A zero-length packet is impossible; a single-beat packet (`in_last` on the first beat) is legal.
- Reset values: `acc_out=0`, `err_cnt=0`, `multi_fault=0`, `sat=0`, `out_valid=0`, `in_ready=1` (state ACCUM).
- Reset mid-packet discards partial sums and counts; no result is emitted.
- `acc_out`, `err_cnt`, `multi_fault` and `sat` are registered outputs. They are visible but not meaningful while `out_valid=0`.

## Timing
- Input-to-state latency is 1 cycle: the beat accepted at edge N is reflected in `acc` after edge N.
- `out_valid` rises the cycle after the edge accepting `in_last`.
- Throughput is 1 beat/cycle within a packet. There is 1 idle input cycle minimum between packets (DONE state), longer under output backpressure.
- The output holds indefinitely while `out_ready=0`. `acc_out`, `err_cnt`, `multi_fault`, `sat` and `out_valid` are all stable until the handshake.
- `in_ready` is combinational from state only, with no path from `out_ready`. No combinational path exists from `prod_*` to any output.
- `rst_n` low overrides any handshake in the same cycle.

## Structure
- Shared package `mul_vote_pkg`:
  - State enum {ACCUM, DONE}.
  - `PROD_W=16` constant.
  - Saturating-increment function used for both `acc` and `err_cnt`.
- One sub-module, `tmr_vote16`: combinational, with ports `prod_a/b/c` → `v`, `mism`, `multi`. It is reused by later voted stages.
- The top level holds the FSM, accumulator, counters and sticky flags.

## Test plan
- Clean packet: 3 beats with all copies equal to 0x0010, 0x0100, 0xFFFF, last on beat 3 → `acc_out=0x01010F`, `err_cnt=0`, `multi_fault=0`, `sat=0`, `out_valid` one cycle after beat 3.
- Single-copy fault:
  - Beat a=0x00FF, b=0x00FF, c=0x80FF; then beat all copies 0x0001 with last → `acc_out=0x000100`, `err_cnt=1`, `multi_fault=0`.
  - Multi-copy fault: a=0x0001, b=0x0002, c=0x0004 single-beat packet → vote 0x0000, `acc_out=0`, `err_cnt=1`, `multi_fault=1`.
- Saturation, with ACC_W=17: beats 0xFFFF ×3 → `acc_out=0x1FFFF`, `sat=1`. Separately, 300 mismatching beats → `err_cnt=255`.
- Backpressure: hold `out_ready=0` for 10 cycles with `in_valid=1` → `in_ready=0` throughout, outputs stable. On `out_ready=1`, the next packet's first beat is accepted the following cycle with `acc` starting from 0.
- Reset: assert `rst_n=0` for one cycle after 2 beats of a packet → all outputs at reset values, `in_ready=1`. The next packet of one beat 0x0005 with last → `acc_out=5`.
